sync_bus_stabilizer: RTL and testbench

SYNC_BUS_STABILIZER -- requirements
Module: sync_bus_stabilizer

---
 rtl/sync_bus_stabilizer.sv | 91 +++++++++
 tb/tb_sync_bus_stabilizer.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/sync_bus_stabilizer.sv
// Qualifies a per-bit-synchronized bus: a value must hold for STABLE_CYCLES samples before it
// is published through a one-entry, latest-wins valid/ready holding register.
module sync_bus_stabilizer #(
  parameter int unsigned WIDTH         = 64,
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic             dest_clk,
  input  logic             dest_rst,
  input  logic [WIDTH-1:0] din,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic             in_stable,
  output logic [15:0]      drop_cnt
);

  localparam logic [7:0] RunMax  = 8'(STABLE_CYCLES);
  localparam logic [7:0] RunQual = 8'(STABLE_CYCLES - 1);

  typedef enum logic {StSettling, StStable} state_e;

  state_e           r_state, w_state_next;
  logic [WIDTH-1:0] r_prev;
  logic [WIDTH-1:0] r_pub;
  logic             r_has_pub;
  logic [7:0]       r_run, w_run_next;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic [15:0]      r_drop_cnt;

  logic w_change, w_qualify, w_publish, w_xfer;

  assign w_change  = (din != r_prev);
  // Run reaches STABLE_CYCLES on this edge; saturation prevents a held value requalifying.
  assign w_qualify = !w_change && (r_run == RunQual);
  assign w_publish = w_qualify && (!r_has_pub || (din != r_pub));
  assign w_xfer    = r_out_valid && out_ready;

  always_comb begin
    w_run_next = r_run;
    if (w_change) begin
      w_run_next = 8'd1;
    end else if (r_run != RunMax) begin
      w_run_next = r_run + 8'd1;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StSettling: if (w_qualify) w_state_next = StStable;
      StStable:   if (w_change)  w_state_next = StSettling;
      default:    w_state_next = StSettling;
    endcase
  end

  always_ff @(posedge dest_clk) begin
    if (dest_rst) begin
      r_state     <= StSettling;
      r_prev      <= '0;
      r_pub       <= '0;
      r_has_pub   <= 1'b0;
      r_run       <= 8'd0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_drop_cnt  <= 16'd0;
    end else begin
      r_state <= w_state_next;
      r_prev  <= din;
      r_run   <= w_run_next;
      if (w_publish) begin
        r_pub       <= din;
        r_has_pub   <= 1'b1;
        r_out_data  <= din;
        r_out_valid <= 1'b1;
        // Overwriting an unaccepted value counts as a drop; a simultaneous transfer does not.
        if (r_out_valid && !out_ready && (r_drop_cnt != 16'hFFFF)) begin
          r_drop_cnt <= r_drop_cnt + 16'd1;
        end
      end else if (w_xfer) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign drop_cnt  = r_drop_cnt;
  assign in_stable = (r_state == StStable);

endmodule

// File: tb/tb_sync_bus_stabilizer.sv
// Directed bench for sync_bus_stabilizer: inputs change and outputs are sampled on the falling edge.
module tb_sync_bus_stabilizer;

  logic        dest_clk = 1'b0;
  logic        dest_rst;
  logic [63:0] din;
  logic        out_valid;
  logic [63:0] out_data;
  logic        out_ready;
  logic        in_stable;
  logic [15:0] drop_cnt;

  int          n_checks = 0;
  int          n_err    = 0;
  int          xfer_cnt = 0;
  logic [63:0] last_xfer = '0;
  int          base;

  sync_bus_stabilizer #(
    .WIDTH        (64),
    .STABLE_CYCLES(4)
  ) dut (
    .dest_clk (dest_clk),
    .dest_rst (dest_rst),
    .din      (din),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_ready(out_ready),
    .in_stable(in_stable),
    .drop_cnt (drop_cnt)
  );

  always #5 dest_clk = ~dest_clk;

  always @(posedge dest_clk) begin
    if (!dest_rst && out_valid && out_ready) begin
      xfer_cnt  <= xfer_cnt + 1;
      last_xfer <= out_data;
    end
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge dest_clk);
      @(negedge dest_clk);
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    dest_rst  = 1'b1;
    din       = '0;
    out_ready = 1'b1;
    @(negedge dest_clk);
    tick(2);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_data", out_data, 64'd0);
    chk("rst_stable", 64'(in_stable), 64'd0);
    chk("rst_drop", 64'(drop_cnt), 64'd0);

    // Zero held after release is still published once.
    dest_rst = 1'b0;
    base = xfer_cnt;
    tick(3);
    chk("zero_early_valid", 64'(out_valid), 64'd0);
    chk("zero_early_stable", 64'(in_stable), 64'd0);
    tick(1);
    chk("zero_valid", 64'(out_valid), 64'd1);
    chk("zero_data", out_data, 64'd0);
    chk("zero_stable", 64'(in_stable), 64'd1);
    tick(1);
    chk("zero_drop_valid", 64'(out_valid), 64'd0);
    tick(3);
    chk("zero_xfers", 64'(xfer_cnt - base), 64'd1);
    chk("zero_still_stable", 64'(in_stable), 64'd1);

    // Step to a new value: visible exactly 4 cycles later.
    base = xfer_cnt;
    din = 64'hDEAD_BEEF_0000_0001;
    tick(3);
    chk("step_early_valid", 64'(out_valid), 64'd0);
    chk("step_early_stable", 64'(in_stable), 64'd0);
    tick(1);
    chk("step_valid", 64'(out_valid), 64'd1);
    chk("step_data", out_data, 64'hDEAD_BEEF_0000_0001);
    tick(1);
    chk("step_fall", 64'(out_valid), 64'd0);
    chk("step_xfers", 64'(xfer_cnt - base), 64'd1);
    chk("step_xdata", last_xfer, 64'hDEAD_BEEF_0000_0001);

    // Skewed transition: the one-cycle intermediate must never be published.
    din = 64'h0;
    tick(6);
    base = xfer_cnt;
    din = 64'h0000_0000_FFFF_0000;
    tick(1);
    din = 64'h0000_0000_FFFF_FFFF;
    tick(3);
    chk("skew_early_valid", 64'(out_valid), 64'd0);
    chk("skew_xfers_mid", 64'(xfer_cnt - base), 64'd0);
    tick(1);
    chk("skew_valid", 64'(out_valid), 64'd1);
    chk("skew_data", out_data, 64'h0000_0000_FFFF_FFFF);
    tick(1);
    chk("skew_xfers", 64'(xfer_cnt - base), 64'd1);
    chk("skew_xdata", last_xfer, 64'h0000_0000_FFFF_FFFF);
    chk("skew_drop", 64'(drop_cnt), 64'd0);

    // Overwrite while stalled.
    out_ready = 1'b0;
    base = xfer_cnt;
    din = 64'h11;
    tick(4);
    chk("ovw_a_valid", 64'(out_valid), 64'd1);
    chk("ovw_a_data", out_data, 64'h11);
    din = 64'h22;
    tick(3);
    chk("ovw_hold_data", out_data, 64'h11);
    tick(1);
    chk("ovw_b_data", out_data, 64'h22);
    chk("ovw_b_valid", 64'(out_valid), 64'd1);
    chk("ovw_drop", 64'(drop_cnt), 64'd1);
    out_ready = 1'b1;
    tick(1);
    chk("ovw_fall", 64'(out_valid), 64'd0);
    chk("ovw_xfers", 64'(xfer_cnt - base), 64'd1);
    chk("ovw_xdata", last_xfer, 64'h22);

    // Glitch away and back: no republish, in_stable returns on requalification.
    base = xfer_cnt;
    din = 64'h33;
    tick(1);
    chk("glitch_stable_lo", 64'(in_stable), 64'd0);
    tick(1);
    din = 64'h22;
    tick(3);
    chk("glitch_stable_lo2", 64'(in_stable), 64'd0);
    tick(1);
    chk("glitch_stable_hi", 64'(in_stable), 64'd1);
    tick(2);
    chk("glitch_no_pub", 64'(out_valid), 64'd0);
    chk("glitch_xfers", 64'(xfer_cnt - base), 64'd0);
    chk("glitch_drop", 64'(drop_cnt), 64'd1);

    // Publish on the same edge as a transfer: no drop counted.
    out_ready = 1'b0;
    din = 64'h44;
    tick(4);
    chk("coin_a_data", out_data, 64'h44);
    din = 64'h55;
    tick(3);
    out_ready = 1'b1;
    tick(1);
    chk("coin_valid", 64'(out_valid), 64'd1);
    chk("coin_data", out_data, 64'h55);
    chk("coin_drop", 64'(drop_cnt), 64'd1);
    chk("coin_xdata_a", last_xfer, 64'h44);
    tick(1);
    chk("coin_fall", 64'(out_valid), 64'd0);
    chk("coin_xdata_b", last_xfer, 64'h55);

    // Reset with a pending value, then the held value is published again.
    out_ready = 1'b0;
    din = 64'h66;
    tick(4);
    chk("rst2_pend", 64'(out_valid), 64'd1);
    dest_rst = 1'b1;
    tick(1);
    chk("rst2_valid", 64'(out_valid), 64'd0);
    chk("rst2_drop", 64'(drop_cnt), 64'd0);
    chk("rst2_data", out_data, 64'd0);
    chk("rst2_stable", 64'(in_stable), 64'd0);
    dest_rst = 1'b0;
    tick(3);
    chk("rst2_early", 64'(out_valid), 64'd0);
    tick(1);
    chk("rst2_repub_valid", 64'(out_valid), 64'd1);
    chk("rst2_repub_data", out_data, 64'h66);
    chk("rst2_repub_drop", 64'(drop_cnt), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
